// File: rtl/axil_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// axil_cfg_sequencer
//
// AXI4-Lite master that programs NUM_REGS consecutive 32-bit slave registers
// from a parallel configuration vector. When VERIFY is set, it then reads each
// register back and compares it with the value written. Completion is reported
// with a one-cycle done pulse. Failures are reported through a sticky
// error/err_code/err_index triple.
//
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   start               one-cycle request; ignored unless idle
//   cfg_data            NUM_REGS x 32-bit register values, word i at [32*i +: 32]
//   busy, done          sequence in progress / one-cycle end-of-sequence pulse
//   error, err_code,    sticky failure flag, cause (1 bresp, 2 rresp,
//   err_index           3 readback mismatch) and failing register index
//   m_axi_aw*/w*/b*     AXI4-Lite write channels
//   m_axi_ar*/r*        AXI4-Lite read channels
// -----------------------------------------------------------------------------
module axil_cfg_sequencer #(
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 4,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     start,
  input  logic [32*NUM_REGS-1:0]   cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_code,
  output logic [3:0]               err_index,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

  state_t                  state;
  logic [3:0]              idx;
  logic [32*NUM_REGS-1:0]  shadow;

  // Byte address of register i, truncated to the AXI address width.
  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [3:0] i);
    logic [31:0] a;
    a = BASE_ADDR + {26'd0, i, 2'b00};
    return a[ADDR_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] reg_word(input logic [32*NUM_REGS-1:0] v,
                                           input logic [3:0] i);
    return v[32*i +: 32];
  endfunction

  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;
  assign m_axi_wstrb  = 4'hF;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= S_IDLE;
      idx           <= 4'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= 2'd0;
      err_index     <= 4'd0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= 32'd0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // The shadow copy is not yet loaded, so word 0 comes straight
            // from cfg_data for the first write.
            shadow        <= cfg_data;
            error         <= 1'b0;
            err_code      <= 2'd0;
            err_index     <= 4'd0;
            idx           <= 4'd0;
            busy          <= 1'b1;
            m_axi_awaddr  <= reg_addr(4'd0);
            m_axi_wdata   <= cfg_data[31:0];
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            state         <= S_WR_REQ;
          end
        end

        S_WR_REQ: begin
          // AW and W complete independently; move on once neither is pending.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              error     <= 1'b1;
              err_code  <= 2'd1;
              err_index <= idx;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else if (idx == LAST) begin
              if (VERIFY) begin
                idx           <= 4'd0;
                m_axi_araddr  <= reg_addr(4'd0);
                m_axi_arvalid <= 1'b1;
                state         <= S_RD_REQ;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_DONE;
              end
            end else begin
              idx           <= idx + 4'd1;
              m_axi_awaddr  <= reg_addr(idx + 4'd1);
              m_axi_wdata   <= reg_word(shadow, idx + 4'd1);
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= S_WR_REQ;
            end
          end
        end

        S_RD_REQ: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_RD_RESP;
          end
        end

        S_RD_RESP: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != 2'b00 || m_axi_rdata != reg_word(shadow, idx)) begin
              error     <= 1'b1;
              err_code  <= (m_axi_rresp != 2'b00) ? 2'd2 : 2'd3;
              err_index <= idx;
              done      <= 1'b1;
              busy      <= 1'b0;
              state     <= S_DONE;
            end else if (idx == LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              idx           <= idx + 4'd1;
              m_axi_araddr  <= reg_addr(idx + 4'd1);
              m_axi_arvalid <= 1'b1;
              state         <= S_RD_REQ;
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
